// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: NUM_CH hobby-servo PWM outputs driven from one shared
// frame counter. Positions land in per-channel shadow registers and are
// applied at the frame boundary, after clamping and a deadband test.
// Optional build macro: SERVO_SLEW_EN (limits the per-frame width change to
// SLEW_STEP ticks; when undefined the applied width jumps to the shadow).

// One servo channel: shadow/active width pair and the registered pulse.
module servo_pwm_lane #(
   parameter logic [31:0] MID_W  = 32'd75000,
   parameter logic [31:0] DB_W   = 32'd50,
   parameter logic [31:0] STEP_W = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_i,
   input  logic [31:0] tgt_i,
   input  logic        boundary_i,
   input  logic [31:0] fc_i,
   input  logic        en_i,
   output logic        pwm_o,
   output logic [31:0] width_o
);

   logic [31:0] shadow_q, shadow_d;
   logic [31:0] active_q, active_d;
   logic        pwm_q, pwm_d;
   logic [31:0] diff;
   logic [31:0] mv;
   logic        up;

   // next-state: last write wins the shadow; active moves only at the boundary
   always_comb begin
      up       = (shadow_q >= active_q);
      diff     = up ? (shadow_q - active_q) : (active_q - shadow_q);
      // an all-ones step means "no slew limit": the whole difference is taken
      mv       = (diff > STEP_W) ? STEP_W : diff;
      shadow_d = wr_i ? tgt_i : shadow_q;
      active_d = active_q;
      if (boundary_i && (diff > DB_W)) begin
         active_d = up ? (active_q + mv) : (active_q - mv);
      end
      // compare against the width in force now, so a boundary update only
      // affects the pulse that starts in the following frame
      pwm_d    = en_i && (fc_i < active_q);
   end

   // channel state; reset aborts any pulse and recentres both widths
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= MID_W;
         active_q <= MID_W;
         pwm_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o   = pwm_q;
   assign width_o = active_q;

endmodule

module servo_pwm_multi #(
   parameter int NUM_CH    = 4,
   parameter int POS_W     = 12,
   parameter int CLK_HZ    = 50000000,
   parameter int FRAME_HZ  = 50,
   parameter int MIN_TICKS = 50000,
   parameter int MAX_TICKS = 100000,
   parameter int DEADBAND  = 50,
   parameter int SLEW_STEP = 500,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pos_valid,
   input  logic [CH_W-1:0]       pos_ch,
   input  logic [POS_W-1:0]      pos_in,
   input  logic [NUM_CH-1:0]     ch_en,
   output logic [NUM_CH-1:0]     pwm_out,
   output logic                  frame_start,
   output logic [NUM_CH*32-1:0]  active_width
);

   localparam int          FRAME_TICKS = CLK_HZ / FRAME_HZ;
   localparam logic [31:0] FT_LAST = 32'(FRAME_TICKS - 1);
   localparam logic [31:0] MIN_W   = 32'(MIN_TICKS);
   localparam logic [31:0] MAX_W   = 32'(MAX_TICKS);
   localparam logic [31:0] SPAN_W  = 32'(MAX_TICKS - MIN_TICKS);
   localparam logic [31:0] MID_W   = 32'((MIN_TICKS + MAX_TICKS) / 2);
   localparam logic [31:0] DB_W    = 32'(DEADBAND);
`ifdef SERVO_SLEW_EN
   localparam logic [31:0] STEP_W  = 32'(SLEW_STEP);
`else
   localparam logic [31:0] STEP_W  = 32'hFFFF_FFFF;
`endif

   // configurations that cannot produce a sane frame are rejected up front
   if (!((MIN_TICKS >= 0) && (MIN_TICKS < MAX_TICKS) && (MAX_TICKS < FRAME_TICKS) &&
         (NUM_CH >= 1) && (NUM_CH <= 16) && (POS_W >= 1) && (SLEW_STEP >= 0) &&
         (DEADBAND >= 0))) begin : g_bad_cfg
      $error("servo_pwm_multi: need MIN_TICKS < MAX_TICKS < FRAME_TICKS and 1 <= NUM_CH <= 16");
   end

   logic [31:0]            fc_q, fc_d;
   logic                   fs_q, fs_d;
   logic                   boundary;
   logic                   wr_ok;
   logic [POS_W+31:0]      prod;
   logic [POS_W+31:0]      scaled;
   logic [POS_W+32:0]      tgt_sum;
   logic [31:0]            tgt;
   logic [NUM_CH-1:0][31:0] width_w;

   // position -> tick mapping at full product width, then clamped
   always_comb begin
      prod    = {32'd0, pos_in} * {{POS_W{1'b0}}, SPAN_W};
      scaled  = prod >> POS_W;
      tgt_sum = {1'b0, scaled} + {{(POS_W+1){1'b0}}, MIN_W};
      if (tgt_sum < {{(POS_W+1){1'b0}}, MIN_W}) begin
         tgt = MIN_W;
      end else if (tgt_sum > {{(POS_W+1){1'b0}}, MAX_W}) begin
         tgt = MAX_W;
      end else begin
         tgt = tgt_sum[31:0];
      end
   end

   // shared frame timing: counter wrap and the frame-start strobe
   always_comb begin
      boundary = (fc_q == FT_LAST);
      fc_d     = boundary ? 32'd0 : (fc_q + 32'd1);
      fs_d     = (fc_q == 32'd0);
      // channel numbers beyond NUM_CH are dropped rather than aliased
      wr_ok    = pos_valid && ({{(32-CH_W){1'b0}}, pos_ch} < 32'(NUM_CH));
   end

   // frame counter and frame_start registers
   always_ff @(posedge clk) begin
      if (reset) begin
         fc_q <= 32'd0;
         fs_q <= 1'b0;
      end else begin
         fc_q <= fc_d;
         fs_q <= fs_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      servo_pwm_lane #(
         .MID_W  (MID_W),
         .DB_W   (DB_W),
         .STEP_W (STEP_W)
      ) u_lane (
         .clk        (clk),
         .reset      (reset),
         .wr_i       (wr_ok && (pos_ch == CH_W'(i))),
         .tgt_i      (tgt),
         .boundary_i (boundary),
         .fc_i       (fc_q),
         .en_i       (ch_en[i]),
         .pwm_o      (pwm_out[i]),
         .width_o    (width_w[i])
      );
   end

   assign frame_start  = fs_q;
   assign active_width = width_w;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: a cycle-level reference model of the frame,
// shadow and boundary rules, directed scenarios and a randomized phase.
// A short frame (3000 ticks) keeps the run brief; widths follow the plan.
module tb_servo_pwm_multi;

   localparam int NCH = 4, POS_W = 12, CLK_HZ = 150000, FRAME_HZ = 50;
   localparam int FT = CLK_HZ / FRAME_HZ;
   localparam int MINT = 1000, MAXT = 2000, DB = 20, STEP = 100;
   localparam int MID = (MINT + MAXT) / 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         pos_valid = 1'b0;
   logic [1:0]   pos_ch = '0;
   logic [11:0]  pos_in = '0;
   logic [3:0]   ch_en = '0;
   logic [3:0]   pwm_out;
   logic         frame_start;
   logic [127:0] active_width;
   logic [2:0]   pwm3;
   logic         fs3;
   logic [95:0]  aw3;

   servo_pwm_multi #(.NUM_CH(NCH), .POS_W(POS_W), .CLK_HZ(CLK_HZ), .FRAME_HZ(FRAME_HZ),
      .MIN_TICKS(MINT), .MAX_TICKS(MAXT), .DEADBAND(DB), .SLEW_STEP(STEP)) dut (
      .clk(clk), .reset(reset), .pos_valid(pos_valid), .pos_ch(pos_ch), .pos_in(pos_in),
      .ch_en(ch_en), .pwm_out(pwm_out), .frame_start(frame_start), .active_width(active_width));

   // three-channel copy: channel select 3 exists on the bus but not in the design
   servo_pwm_multi #(.NUM_CH(3), .POS_W(POS_W), .CLK_HZ(CLK_HZ), .FRAME_HZ(FRAME_HZ),
      .MIN_TICKS(MINT), .MAX_TICKS(MAXT), .DEADBAND(DB), .SLEW_STEP(STEP)) dut3 (
      .clk(clk), .reset(reset), .pos_valid(pos_valid), .pos_ch(pos_ch), .pos_in(pos_in),
      .ch_en(ch_en[2:0]), .pwm_out(pwm3), .frame_start(fs3), .active_width(aw3));

   always #5 clk = ~clk;

   int n_assert = 0, n_fail = 0;

   // reference state
   int       m_fc = 0;
   int       m_sh[NCH];
   int       m_ac[NCH];
   logic [3:0] m_pwm = '0;
   logic     m_fs = 1'b0;
   int       mism = 0;
   int       cnt[NCH];
   int       expw[NCH];
   bit       clean = 0;
   longint   cyc = 0, last_fs = 0;
   bit       fs_valid = 0;
   logic [3:0] prev_en = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int tgt_of(input int p);
      longint t;
      t = MINT + (longint'(p) * (MAXT - MINT)) / (longint'(1) << POS_W);
      if (t < MINT) t = MINT;
      if (t > MAXT) t = MAXT;
      return int'(t);
   endfunction

   function automatic logic [127:0] pack_ac();
      logic [127:0] v;
      for (int i = 0; i < NCH; i++) v[i*32 +: 32] = 32'(m_ac[i]);
      return v;
   endfunction

   function automatic logic [31:0] aw(input int i);
      return active_width[i*32 +: 32];
   endfunction

   // one clock: advance the model with the inputs seen at this edge, then check
   task automatic step();
      bit start, fin;
      int d, mv;
      logic [127:0] pk;
      start = 0; fin = 0;
      if (reset) begin
         m_fc = 0; m_pwm = '0; m_fs = 1'b0;
         for (int i = 0; i < NCH; i++) begin m_sh[i] = MID; m_ac[i] = MID; end
         clean = 0; fs_valid = 0;
      end else begin
         start = (m_fc == 0);
         fin   = (m_fc == FT - 1);
         if (start) begin
            clean = 1;
            for (int i = 0; i < NCH; i++) begin
               cnt[i]  = 0;
               expw[i] = ch_en[i] ? m_ac[i] : 0;
            end
         end else if (ch_en !== prev_en) begin
            clean = 0;
         end
         for (int i = 0; i < NCH; i++) m_pwm[i] = ch_en[i] && (m_fc < m_ac[i]);
         m_fs = (m_fc == 0);
         if (fin) begin
            for (int i = 0; i < NCH; i++) begin
               d = (m_sh[i] > m_ac[i]) ? m_sh[i] - m_ac[i] : m_ac[i] - m_sh[i];
               if (d > DB) begin
`ifdef SERVO_SLEW_EN
                  mv = (d > STEP) ? STEP : d;
`else
                  mv = d;
`endif
                  m_ac[i] = (m_sh[i] > m_ac[i]) ? m_ac[i] + mv : m_ac[i] - mv;
               end
            end
         end
         if (pos_valid) m_sh[pos_ch] = tgt_of(int'(pos_in));
         m_fc = fin ? 0 : m_fc + 1;
      end
      prev_en = ch_en;
      @(posedge clk);
      #1;
      cyc++;
      pk = pack_ac();
      if ({pwm_out, frame_start, active_width} !== {m_pwm, m_fs, pk}) mism++;
      if ({pwm3, fs3, aw3} !== {m_pwm[2:0], m_fs, pk[95:0]}) mism++;
      for (int i = 0; i < NCH; i++) cnt[i] += int'(pwm_out[i]);
      if (frame_start === 1'b1) begin
         if (fs_valid) chk("fs_period", 64'(cyc - last_fs), 64'(FT));
         last_fs = cyc; fs_valid = 1;
      end
      if (fin) begin
         chk("cycle_mismatches", 64'(mism), 64'd0);
         mism = 0;
         if (clean) for (int i = 0; i < NCH; i++)
            chk($sformatf("pulse_len_ch%0d", i), 64'(cnt[i]), 64'(expw[i]));
      end
   endtask

   task automatic run_to(input int f);
      int guard = 0;
      while (m_fc != f && guard < FT + 2) begin step(); guard++; end
      if (m_fc != f) chk("run_to_bound", 64'(m_fc), 64'(f));
   endtask

   task automatic next_frame();
      run_to(FT - 1);
      step();
   endtask

   task automatic write(input int ch, input int p);
      pos_valid = 1'b1; pos_ch = 2'(ch); pos_in = 12'(p);
      step();
      pos_valid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef SERVO_SLEW_EN
      int slew_exp[6] = '{1600, 1700, 1800, 1900, 1999, 1999};
`endif
      for (int i = 0; i < NCH; i++) begin m_sh[i] = MID; m_ac[i] = MID; cnt[i] = 0; expw[i] = 0; end
      reset = 1'b1; ch_en = 4'h0;
      repeat (3) step();
      chk("reset_pwm", 64'(pwm_out), 64'd0);
      chk("reset_fs", 64'(frame_start), 64'd0);
      chk("reset_width", 64'(aw(0)), 64'd1500);
      chk("reset_width3", 64'(aw(3)), 64'd1500);
      reset = 1'b0; ch_en = 4'hF;
      next_frame();

`ifndef SERVO_SLEW_EN
      // endpoint mapping
      run_to(100);
      write(0, 0); write(1, 4095); write(2, 2048);
      next_frame();
      chk("ep_ch0", 64'(aw(0)), 64'd1000);
      chk("ep_ch1", 64'(aw(1)), 64'd1999);
      chk("ep_ch2", 64'(aw(2)), 64'd1500);
      chk("ep_ch3", 64'(aw(3)), 64'd1500);
      // deadband
      run_to(100);
      write(0, 2048); write(1, 2048);
      next_frame();
      chk("db_recentre0", 64'(aw(0)), 64'd1500);
      chk("db_recentre1", 64'(aw(1)), 64'd1500);
      run_to(100); write(0, 2089); next_frame();
      chk("db_hold10", 64'(aw(0)), 64'd1500);
      run_to(100); write(0, 2130); next_frame();
      chk("db_hold20", 64'(aw(0)), 64'd1500);
      run_to(100); write(0, 2150); next_frame();
      chk("db_move24", 64'(aw(0)), 64'd1524);
      // write landing in the boundary cycle
      run_to(FT - 1);
      write(1, 4095);
      chk("bwr_same", 64'(aw(1)), 64'd1500);
      next_frame();
      chk("bwr_next", 64'(aw(1)), 64'd1999);
      // select 3 reaches channel 3 of the four-channel copy only
      run_to(100); write(3, 0); next_frame();
      chk("ch3_written", 64'(aw(3)), 64'd1000);
      chk("ignore_sel3", 64'(aw3), {32'd0, 32'd1500, 32'd1999, 32'd1524} & 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
      // enable and reset mid-pulse
      run_to(700);
      ch_en[2] = 1'b0; step();
      chk("dis_ch2", 64'(pwm_out[2]), 64'd0);
      chk("dis_ch0_on", 64'(pwm_out[0]), 64'd1);
      run_to(750);
      chk("dis_hold", 64'(pwm_out[2]), 64'd0);
      ch_en[2] = 1'b1; step();
      chk("reen_partial", 64'(pwm_out[2]), 64'd1);
      run_to(800);
      reset = 1'b1; step();
      chk("midrst_pwm", 64'(pwm_out), 64'd0);
      chk("midrst_w0", 64'(aw(0)), 64'd1500);
      chk("midrst_w1", 64'(aw(1)), 64'd1500);
      step();
      reset = 1'b0;
      next_frame();
`else
      run_to(100);
      write(0, 4095);
      for (int k = 0; k < 6; k++) begin
         next_frame();
         chk($sformatf("slew_f%0d", k), 64'(aw(0)), 64'(slew_exp[k]));
      end
`endif

      // randomized writes and enables against the model
      ch_en = 4'hF;
      for (int n = 0; n < 4 * FT; n++) begin
         if ($urandom_range(0, 63) == 0) begin
            write(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
         end else begin
            if ($urandom_range(0, 1999) == 0) ch_en = 4'($urandom);
            step();
         end
      end
      run_to(FT - 1);
      write(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
      next_frame();
      next_frame();
      chk("tail_mismatches", 64'(mism), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
